int_to_float: RTL and testbench

- Converts a signed two's-complement ADS1292 sample into an IEEE-754 single-precision float.
- Sits directly upstream of the float adder and multiplier in the ADS1292 filter datapath, and uses the same STB/ACK two-phase handshake.
- Multi-cycle FSM with a one-bit-per-cycle normaliser and round-to-nearest-even, so any supported input width is handled.

---
 rtl/int_to_float.sv | 166 ++++++++++++++++
 tb/tb_int_to_float.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// int_to_float: converts a signed IN_W-bit ADS1292 sample into an IEEE-754
// single-precision float. Uses a STB/ACK handshake on both sides, a one-bit-
// per-cycle normaliser and round-to-nearest-even on the 24-bit mantissa.
`timescale 1ns/1ps

module int_to_float #(
    parameter int IN_W = 24
) (
    input  logic            i_CLK,
    input  logic            i_RSTN,
    input  logic [IN_W-1:0] i_A,
    input  logic            i_A_STB,
    output logic            o_A_ACK,
    output logic [31:0]     o_Z,
    output logic            o_Z_STB,
    input  logic            i_Z_ACK
);

    // Normalised magnitude padded with enough zeros below it that the
    // mantissa, guard, round and sticky fields always exist for any IN_W.
    localparam int EXT_W = IN_W + 27;

    typedef enum logic [2:0] {
        GET_A,
        CONVERT_0,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   a_q, a_d;
    logic [IN_W-1:0]   mag_q, mag_d;
    logic [7:0]        z_e_q, z_e_d;
    logic              z_s_q, z_s_d;
    logic [23:0]       m_q, m_d;
    logic [31:0]       z_q, z_d;
    logic              a_ack_q, a_ack_d;
    logic              z_stb_q, z_stb_d;
    logic [31:0]       o_z_q, o_z_d;

    logic [EXT_W-1:0]  ext_mag;
    logic [23:0]       m_keep;
    logic              guard_bit;
    logic              round_bit;
    logic              sticky_bit;

    assign o_A_ACK = a_ack_q;
    assign o_Z     = o_z_q;
    assign o_Z_STB = z_stb_q;

    // Split the normalised magnitude into kept mantissa and rounding bits.
    always_comb begin
        ext_mag    = {mag_q, 27'd0};
        m_keep     = ext_mag[EXT_W-1 -: 24];
        guard_bit  = ext_mag[IN_W+2];
        round_bit  = ext_mag[IN_W+1];
        sticky_bit = |ext_mag[IN_W:0];
    end

    // Next-state and datapath updates for the conversion sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mag_d   = mag_q;
        z_e_d   = z_e_q;
        z_s_d   = z_s_q;
        m_d     = m_q;
        z_d     = z_q;
        a_ack_d = a_ack_q;
        z_stb_d = z_stb_q;
        o_z_d   = o_z_q;

        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && i_A_STB) begin
                    a_d     = i_A;
                    a_ack_d = 1'b0;
                    state_d = CONVERT_0;
                end
            end

            CONVERT_0: begin
                if (a_q == '0) begin
                    z_d     = 32'h0000_0000;
                    state_d = PUT_Z;
                end else begin
                    z_s_d   = a_q[IN_W-1];
                    mag_d   = a_q[IN_W-1] ? (~a_q + {{(IN_W-1){1'b0}}, 1'b1}) : a_q;
                    z_e_d   = 8'(IN_W - 1);
                    state_d = NORMALISE;
                end
            end

            NORMALISE: begin
                if (mag_q[IN_W-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    z_e_d = z_e_q - 8'd1;
                end
            end

            ROUND: begin
                m_d = m_keep;
                if (guard_bit && (round_bit || sticky_bit || m_keep[0])) begin
                    if (m_keep == 24'hFF_FFFF) begin
                        m_d   = 24'h80_0000;
                        z_e_d = z_e_q + 8'd1;
                    end else begin
                        m_d = m_keep + 24'd1;
                    end
                end
                state_d = PACK;
            end

            PACK: begin
                z_d     = {z_s_q, z_e_q + 8'd127, m_q[22:0]};
                state_d = PUT_Z;
            end

            PUT_Z: begin
                z_stb_d = 1'b1;
                o_z_d   = z_q;
                if (z_stb_q && i_Z_ACK) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end

            default: begin
                state_d = GET_A;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q <= GET_A;
            a_q     <= '0;
            mag_q   <= '0;
            z_e_q   <= 8'd0;
            z_s_q   <= 1'b0;
            m_q     <= 24'd0;
            z_q     <= 32'd0;
            a_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            o_z_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            mag_q   <= mag_d;
            z_e_q   <= z_e_d;
            z_s_q   <= z_s_d;
            m_q     <= m_d;
            z_q     <= z_d;
            a_ack_q <= a_ack_d;
            z_stb_q <= z_stb_d;
            o_z_q   <= o_z_d;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Directed testbench for int_to_float: a 24-bit instance for the sample path,
// handshake and reset cases, and a 32-bit instance for the rounding cases.
`timescale 1ns/1ps

module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [23:0] a24;
    logic        a24_stb;
    logic        a24_ack;
    logic [31:0] z24;
    logic        z24_stb;
    logic        z24_ack;

    logic [31:0] a32;
    logic        a32_stb;
    logic        a32_ack;
    logic [31:0] z32;
    logic        z32_stb;
    logic        z32_ack;

    bit          use32_sel;
    logic        sel_ack;
    logic        sel_stb;
    logic [31:0] sel_z;

    int          compared   = 0;
    int          mismatched = 0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    int_to_float #(.IN_W(24)) dut24 (
        .i_CLK   (clk),
        .i_RSTN  (rst_n),
        .i_A     (a24),
        .i_A_STB (a24_stb),
        .o_A_ACK (a24_ack),
        .o_Z     (z24),
        .o_Z_STB (z24_stb),
        .i_Z_ACK (z24_ack)
    );

    int_to_float #(.IN_W(32)) dut32 (
        .i_CLK   (clk),
        .i_RSTN  (rst_n),
        .i_A     (a32),
        .i_A_STB (a32_stb),
        .o_A_ACK (a32_ack),
        .o_Z     (z32),
        .o_Z_STB (z32_stb),
        .i_Z_ACK (z32_ack)
    );

    // Route the outputs of whichever instance the current step is using.
    always_comb begin
        sel_ack = use32_sel ? a32_ack : a24_ack;
        sel_stb = use32_sel ? z32_stb : z24_stb;
        sel_z   = use32_sel ? z32     : z24;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction: wait for ACK, present the sample, count edges from
    // the capture edge to o_Z_STB, check the result, optionally stall the
    // consumer, then acknowledge and check the return to get_a.
    task automatic applyStimulus(input string tag, input bit use32,
                                 input logic [31:0] value, input logic [31:0] expected,
                                 input int exp_latency, input int stall_cycles);
        int wait_count;
        int edges;
        use32_sel  = use32;
        wait_count = 0;
        @(negedge clk);
        while (sel_ack !== 1'b1 && wait_count < 50) begin
            @(negedge clk);
            wait_count++;
        end
        checkOutput({tag, " ack_ready"}, {31'd0, sel_ack}, 32'd1);
        if (use32) begin
            a32     = value;
            a32_stb = 1'b1;
        end else begin
            a24     = value[23:0];
            a24_stb = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        a24_stb = 1'b0;
        a32_stb = 1'b0;
        checkOutput({tag, " ack_drop"}, {31'd0, sel_ack}, 32'd0);
        edges = 0;
        while (sel_stb !== 1'b1 && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'(exp_latency));
        checkOutput({tag, " result"}, sel_z, expected);
        for (int i = 0; i < stall_cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " stall_stb"}, {31'd0, sel_stb}, 32'd1);
            checkOutput({tag, " stall_z"}, sel_z, expected);
            checkOutput({tag, " stall_ack"}, {31'd0, sel_ack}, 32'd0);
        end
        if (use32) z32_ack = 1'b1;
        else       z24_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z24_ack = 1'b0;
        z32_ack = 1'b0;
        checkOutput({tag, " stb_drop"}, {31'd0, sel_stb}, 32'd0);
        checkOutput({tag, " ack_low"}, {31'd0, sel_ack}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " ack_rise"}, {31'd0, sel_ack}, 32'd1);
    endtask

    // Hard time limit so a stuck DUT cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        a24       = '0;
        a24_stb   = 1'b0;
        z24_ack   = 1'b0;
        a32       = '0;
        a32_stb   = 1'b0;
        z32_ack   = 1'b0;
        use32_sel = 1'b0;

        // Outputs held clear while reset is asserted across several edges.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset ack", {31'd0, a24_ack}, 32'd0);
            checkOutput("reset stb", {31'd0, z24_stb}, 32'd0);
            checkOutput("reset z", z24, 32'd0);
        end
        checkOutput("reset z32", z32, 32'd0);

        // ACK rises on the first edge after release, not before.
        rst_n = 1'b1;
        #1;
        checkOutput("release ack_before_edge", {31'd0, a24_ack}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("release ack_after_edge", {31'd0, a24_ack}, 32'd1);

        // 24-bit samples; latency is L+5 with L leading zeros of |a|, or 2 for zero.
        applyStimulus("zero",     1'b0, 32'h0000_0000, 32'h0000_0000,  2, 0);
        applyStimulus("one",      1'b0, 32'h0000_0001, 32'h3F80_0000, 28, 0);
        applyStimulus("minus1",   1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 28, 0);
        applyStimulus("maxpos",   1'b0, 32'h007F_FFFF, 32'h4AFF_FFFE,  6, 10);
        applyStimulus("fullneg",  1'b0, 32'h0080_0000, 32'hCB00_0000,  5, 0);

        // 32-bit rounding: tie-to-even down, tie up, and mantissa carry-out.
        applyStimulus("tie_down", 1'b1, 32'd16777217,  32'h4B80_0000, 12, 0);
        applyStimulus("tie_up",   1'b1, 32'd16777219,  32'h4B80_0002, 12, 0);
        applyStimulus("carry",    1'b1, 32'h7FFF_FFFF, 32'h4F00_0000,  6, 0);

        // Reset during normalisation of input 1: no output, then a clean conversion.
        use32_sel = 1'b0;
        @(negedge clk);
        a24     = 24'h00_0001;
        a24_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a24_stb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset stb", {31'd0, z24_stb}, 32'd0);
        checkOutput("midreset ack", {31'd0, a24_ack}, 32'd0);
        checkOutput("midreset z", z24, 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midreset hold_stb", {31'd0, z24_stb}, 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus("minus5",   1'b0, 32'hFFFF_FFFB, 32'hC0A0_0000, 26, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
